// File: rtl/gpio_pkg.sv
// GPIO register map and debounce helpers shared by the MMIO block and its filters.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package gpio_pkg;

  localparam int DATA_W = 16;

  // Register offsets on the 3-bit address bus.
  typedef enum logic [2:0] {
    REG_OUT     = 3'd0,
    REG_OUT_SET = 3'd1,
    REG_OUT_CLR = 3'd2,
    REG_OUT_TGL = 3'd3,
    REG_IN      = 3'd4,
    REG_RISE    = 3'd5,
    REG_FALL    = 3'd6,
    REG_IRQ_EN  = 3'd7
  } reg_addr_e;

  // Debounce counter width; the counter tops out at db_cycles-1 so it never wraps.
  function automatic int db_cnt_w(input int db_cycles);
    return $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/db_filter.sv
// One-channel input conditioner: 2-flop synchronizer, mismatch counter, stable bit, edge pulses.
// Latency: stable bit follows a held input change DB_CYCLES+2 clocks after it arrives.
// Backpressure: none; rise/fall are single-cycle pulses coincident with the stable-bit update.
module db_filter import gpio_pkg::*; #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = db_cnt_w(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchronize, count consecutive mismatch cycles, accept the new level on the last one.
  always_comb begin
    sync1_d  = din;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    rise     = 1'b0;
    fall     = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        rise     = sync2_q;
        fall     = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset also aborts any debounce in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: output register with set/clear/toggle, debounced inputs, sticky edge flags, level irq.
// Latency: reads return registered data one clock after the cs/read cycle; writes visible next cycle.
// Backpressure: none; one access per cycle is always accepted.
module gpio_mmio import gpio_pkg::*; #(
  parameter int N_IN      = 8,
  parameter int N_OUT     = 8,
  parameter int DB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs,
  input  logic              write,
  input  logic [2:0]        addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  input  logic [N_IN-1:0]   gpio_in,
  output logic [N_OUT-1:0]  gpio_out,
  output logic              irq
);

  logic [N_IN-1:0]   in_stable, rise_p, fall_p;
  logic [N_OUT-1:0]  out_q, out_d;
  logic [N_IN-1:0]   irq_en_q, irq_en_d;
  logic [N_IN-1:0]   rise_q, rise_d;
  logic [N_IN-1:0]   fall_q, fall_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [15:0]       rd_val;
  logic [N_OUT-1:0]  w_out;
  logic [N_IN-1:0]   w_in;
  logic              wr_en, rd_en;
  logic              unused_wdata;
  reg_addr_e         reg_sel;

  assign wr_en        = cs & write;
  assign rd_en        = cs & ~write;
  assign reg_sel      = reg_addr_e'(addr);
  assign w_out        = wdata[N_OUT-1:0];
  assign w_in         = wdata[N_IN-1:0];
  assign unused_wdata = ^wdata;

  for (genvar i = 0; i < N_IN; i++) begin : g_db
    db_filter #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (gpio_in[i]),
      .stable  (in_stable[i]),
      .rise    (rise_p[i]),
      .fall    (fall_p[i])
    );
  end

  // Register writes; new edges are OR'd in last so they win over a same-cycle W1C.
  always_comb begin
    out_d    = out_q;
    irq_en_d = irq_en_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    if (wr_en) begin
      case (reg_sel)
        REG_OUT:     out_d    = w_out;
        REG_OUT_SET: out_d    = out_q | w_out;
        REG_OUT_CLR: out_d    = out_q & ~w_out;
        REG_OUT_TGL: out_d    = out_q ^ w_out;
        REG_RISE:    rise_d   = rise_q & ~w_in;
        REG_FALL:    fall_d   = fall_q & ~w_in;
        REG_IRQ_EN:  irq_en_d = w_in;
        default:     ;
      endcase
    end
    rise_d = rise_d | rise_p;
    fall_d = fall_d | fall_p;
  end

  // Read mux, zero-extended to the bus; rdata only loads on a read strobe and holds otherwise.
  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_OUT:    rd_val[N_OUT-1:0] = out_q;
      REG_IN:     rd_val[N_IN-1:0]  = in_stable;
      REG_RISE:   rd_val[N_IN-1:0]  = rise_q;
      REG_FALL:   rd_val[N_IN-1:0]  = fall_q;
      REG_IRQ_EN: rd_val[N_IN-1:0]  = irq_en_q;
      default:    rd_val = '0;
    endcase
    rdata_d = rd_en ? rd_val : rdata_q;
  end

  // Register file state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q    <= '0;
      irq_en_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      rdata_q  <= '0;
    end else begin
      out_q    <= out_d;
      irq_en_q <= irq_en_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      rdata_q  <= rdata_d;
    end
  end

  assign gpio_out = out_q;
  assign rdata    = rdata_q;
  assign irq      = |((rise_q | fall_q) & irq_en_q);

endmodule

// File: tb/tb_gpio_mmio.sv
// Directed bench for gpio_mmio: register vector table plus hand-timed debounce, irq and reset sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_gpio_mmio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0;
  logic        write = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [15:0] wdata = 16'h0;
  logic [15:0] rdata;
  logic [7:0]  gpio_in = 8'h00;
  logic [7:0]  gpio_out;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;

  gpio_mmio #(.N_IN(8), .N_OUT(8), .DB_CYCLES(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cs       (cs),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  exp_out;
    logic        chk_rd;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; performs one access on the next posedge and returns at the following negedge.
  task automatic access(input logic wr, input logic [2:0] a, input logic [15:0] d);
    cs = 1'b1;
    write = wr;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1;
    cs = 1'b0;
    write = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
    access(1'b0, a, 16'h0);
    chk(name, {16'h0, rdata}, {16'h0, exp});
  endtask

  // Counts posedges (starting from `start`) until irq rises; 0 means it never did within the bound.
  task automatic wait_irq(input int start, output int first);
    first = 0;
    for (int k = start; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (irq && first == 0) first = k;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int  first;
    logic seen_irq;

    vecs[0]  = '{1'b1, 3'd0, 16'h00A5, 8'hA5, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 3'd1, 16'h0100, 8'hA5, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 3'd2, 16'h0005, 8'hA0, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 3'd3, 16'h00FF, 8'h5F, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 3'd0, 16'h0000, 8'h5F, 1'b1, 16'h005F};
    vecs[5]  = '{1'b0, 3'd1, 16'h0000, 8'h5F, 1'b1, 16'h0000};
    vecs[6]  = '{1'b0, 3'd0, 16'h0000, 8'h5F, 1'b1, 16'h005F};
    vecs[7]  = '{1'b0, 3'd2, 16'h0000, 8'h5F, 1'b1, 16'h0000};
    vecs[8]  = '{1'b0, 3'd0, 16'h0000, 8'h5F, 1'b1, 16'h005F};
    vecs[9]  = '{1'b0, 3'd3, 16'h0000, 8'h5F, 1'b1, 16'h0000};
    vecs[10] = '{1'b0, 3'd4, 16'h0000, 8'h5F, 1'b1, 16'h0000};
    vecs[11] = '{1'b1, 3'd7, 16'hFFFF, 8'h5F, 1'b0, 16'h0000};
    vecs[12] = '{1'b0, 3'd7, 16'h0000, 8'h5F, 1'b1, 16'h00FF};
    vecs[13] = '{1'b1, 3'd0, 16'hFF3C, 8'h3C, 1'b0, 16'h0000};

    // Reset state
    #12;
    chk("reset gpio_out", {24'h0, gpio_out}, 32'h0);
    chk("reset rdata", {16'h0, rdata}, 32'h0);
    chk("reset irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Register table
    for (int i = 0; i < 14; i++) begin
      access(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec[%0d] gpio_out", i), {24'h0, gpio_out}, {24'h0, vecs[i].exp_out});
      if (vecs[i].chk_rd)
        chk($sformatf("vec[%0d] rdata", i), {16'h0, rdata}, {16'h0, vecs[i].exp_rd});
      chk($sformatf("vec[%0d] irq", i), {31'h0, irq}, 32'h0);
    end

    // Read latency: rdata holds until the read edge, then shows IN
    rd_chk("read OUT before latency", 3'd0, 16'h003C);
    cs = 1'b1; write = 1'b0; addr = 3'd4;
    #1;
    chk("rdata holds before read edge", {16'h0, rdata}, 32'h003C);
    @(posedge clk);
    #1;
    cs = 1'b0;
    chk("rdata IN one cycle later", {16'h0, rdata}, 32'h0000);
    @(negedge clk);

    // 10-cycle glitch on input 0 is filtered out
    seen_irq = 1'b0;
    gpio_in[0] = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    gpio_in[0] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (irq) seen_irq = 1'b1;
    end
    @(negedge clk);
    chk("glitch irq", {31'h0, seen_irq}, 32'h0);
    rd_chk("glitch IN", 3'd4, 16'h0000);
    rd_chk("glitch RISE", 3'd5, 16'h0000);

    // Held rise on input 2 appears exactly 18 clocks after the input edge
    access(1'b1, 3'd7, 16'h0004);
    gpio_in[2] = 1'b1;
    wait_irq(1, first);
    chk("rise latency cycles", first, 32'd18);
    rd_chk("IN after rise", 3'd4, 16'h0004);
    rd_chk("RISE after rise", 3'd5, 16'h0004);
    rd_chk("FALL after rise", 3'd6, 16'h0000);

    // W1C clears the flag and drops irq
    access(1'b1, 3'd5, 16'h0004);
    chk("irq after RISE W1C", {31'h0, irq}, 32'h0);
    rd_chk("RISE after W1C", 3'd5, 16'h0000);

    // Read of FALL coincident with the edge returns the pre-edge value
    gpio_in[2] = 1'b0;
    repeat (17) @(posedge clk);
    @(negedge clk);
    rd_chk("FALL read on edge", 3'd6, 16'h0000);
    chk("irq on fall", {31'h0, irq}, 32'h1);
    rd_chk("FALL after edge", 3'd6, 16'h0004);
    access(1'b1, 3'd6, 16'h0004);
    chk("irq after FALL W1C", {31'h0, irq}, 32'h0);

    // W1C coincident with a new rise: the edge wins
    gpio_in[2] = 1'b1;
    repeat (17) @(posedge clk);
    @(negedge clk);
    access(1'b1, 3'd5, 16'h0004);
    chk("irq edge beats W1C", {31'h0, irq}, 32'h1);
    rd_chk("RISE edge beats W1C", 3'd5, 16'h0004);

    // Reset mid-debounce with outputs set
    access(1'b1, 3'd0, 16'h00FF);
    rd_chk("OUT before reset", 3'd0, 16'h00FF);
    gpio_in[5] = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset gpio_out", {24'h0, gpio_out}, 32'h0);
    chk("async reset rdata", {16'h0, rdata}, 32'h0);
    chk("async reset irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk("IN after reset", 3'd4, 16'h0000);
    rd_chk("IRQ_EN after reset", 3'd7, 16'h0000);
    access(1'b1, 3'd7, 16'h0024);
    wait_irq(4, first);
    chk("post-reset rise latency", first, 32'd18);
    rd_chk("RISE after reset release", 3'd5, 16'h0024);
    rd_chk("IN after reset release", 3'd4, 16'h0024);
    rd_chk("FALL after reset release", 3'd6, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
